// File: rtl/mcycle_pkg.sv
// rtl/mcycle_pkg.sv - shared types and constants for the multi-cycle MUL/DIV sequencer
package mcycle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Index of the carry flag inside ALU_Flags {N,Z,C,V}
  localparam int FLAG_C = 1;

endpackage

// File: rtl/mcycle_alu_sequencer.sv
// rtl/mcycle_alu_sequencer.sv - multi-cycle unsigned MUL/DIV sequencer borrowing the shared ALU
//
// Ports:
//   CLK, RESETn            clock (rising edge), asynchronous active-low reset
//   Start, MCycleOp        operation request (sampled in IDLE/DONE), 0=MUL 1=DIV
//   Operand1, Operand2     multiplicand/dividend, multiplier/divisor
//   Busy, Done             pipeline stall, one-cycle result-valid pulse
//   Result1, Result2       MUL product low/high, DIV quotient/remainder
//   ALU_Own, ALU_*         ALU input mux select and ALU operand/control drive
//   ALU_Result, ALU_Flags  shared ALU outputs, consumed in the same cycle
module mcycle_alu_sequencer
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             ALU_Own,
  output logic [WIDTH-1:0] ALU_SrcA,
  output logic [WIDTH-1:0] ALU_SrcB,
  output logic [3:0]       ALU_Control,
  output logic             ALU_isArith,
  output logic             ALU_isADC,
  output logic             ALU_CFlag,
  input  logic [WIDTH-1:0] ALU_Result,
  input  logic [3:0]       ALU_Flags
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  // hi_q: product high half (MUL) / partial remainder (DIV)
  // lo_q: multiplier being consumed (MUL) / dividend shifting into quotient (DIV)
  // opb_q: multiplicand (MUL) / divisor (DIV)
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res1_q, res1_d;
  logic [WIDTH-1:0] res2_q, res2_d;

  logic [WIDTH-1:0] div_sh;
  logic             carry;
  logic             qbit;
  logic             unused_flags;

  assign div_sh       = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign carry        = ALU_Flags[FLAG_C];
  // A set top bit means the 33-bit shifted remainder always covers the divisor
  assign qbit         = hi_q[WIDTH-1] | carry;
  assign unused_flags = ^{ALU_Flags[3:2], ALU_Flags[0]};

  assign Done    = (state_q == ST_DONE);
  assign Result1 = res1_q;
  assign Result2 = res2_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
    end
  end

  // ALU drive and stall depend only on registered state and Start, never on
  // ALU_Result, so the ALU path stays acyclic.
  always_comb begin
    Busy        = 1'b0;
    ALU_Own     = 1'b0;
    ALU_SrcA    = '0;
    ALU_SrcB    = '0;
    ALU_Control = ALU_ADD;
    ALU_isArith = 1'b0;
    ALU_isADC   = 1'b0;
    ALU_CFlag   = 1'b0;
    case (state_q)
      ST_RUN: begin
        Busy        = 1'b1;
        ALU_Own     = 1'b1;
        ALU_isArith = 1'b1;
        ALU_CFlag   = 1'b1;
        ALU_SrcB    = opb_q;
        if (op_q == OP_DIV) begin
          ALU_SrcA    = div_sh;
          ALU_Control = ALU_SUB;
        end else begin
          ALU_SrcA    = hi_q;
          ALU_Control = ALU_ADD;
        end
      end
      default: Busy = Start;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (Start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          op_d    = MCycleOp;
          hi_d    = '0;
          if (MCycleOp == OP_DIV) begin
            lo_d  = Operand1;
            opb_d = Operand2;
          end else begin
            lo_d  = Operand2;
            opb_d = Operand1;
          end
        end
      end
      ST_RUN: begin
        if (op_q == OP_DIV) begin
          hi_d = qbit ? ALU_Result : div_sh;
          lo_d = {lo_q[WIDTH-2:0], qbit};
        end else if (lo_q[0]) begin
          hi_d = {carry, ALU_Result[WIDTH-1:1]};
          lo_d = {ALU_Result[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[WIDTH-1:1]};
          lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          res1_d  = lo_d;
          res2_d  = hi_d;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mcycle_alu_sequencer.sv
// tb/tb_mcycle_alu_sequencer.sv - self-checking bench for mcycle_alu_sequencer with an ALU in the loop
module tb_mcycle_alu_sequencer;

  logic        CLK;
  logic        RESETn;
  logic        Start;
  logic        MCycleOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic        Busy;
  logic        Done;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        ALU_Own;
  logic [31:0] ALU_SrcA;
  logic [31:0] ALU_SrcB;
  logic [3:0]  ALU_Control;
  logic        ALU_isArith;
  logic        ALU_isADC;
  logic        ALU_CFlag;
  logic [31:0] ALU_Result;
  logic [3:0]  ALU_Flags;

  mcycle_alu_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .Start       (Start),
    .MCycleOp    (MCycleOp),
    .Operand1    (Operand1),
    .Operand2    (Operand2),
    .Busy        (Busy),
    .Done        (Done),
    .Result1     (Result1),
    .Result2     (Result2),
    .ALU_Own     (ALU_Own),
    .ALU_SrcA    (ALU_SrcA),
    .ALU_SrcB    (ALU_SrcB),
    .ALU_Control (ALU_Control),
    .ALU_isArith (ALU_isArith),
    .ALU_isADC   (ALU_isADC),
    .ALU_CFlag   (ALU_CFlag),
    .ALU_Result  (ALU_Result),
    .ALU_Flags   (ALU_Flags)
  );

  always #5 CLK = ~CLK;

  // Shared ALU: ADD / SUB (A + ~B + Cin), flags {N,Z,C,V}
  logic        alu_sub;
  logic [31:0] alu_b;
  logic        alu_cin;
  logic [32:0] alu_sum;
  logic        alu_v;
  assign alu_sub    = (ALU_Control == 4'b0001);
  assign alu_b      = alu_sub ? ~ALU_SrcB : ALU_SrcB;
  assign alu_cin    = alu_sub ? ALU_CFlag : (ALU_isADC & ALU_CFlag);
  assign alu_sum    = {1'b0, ALU_SrcA} + {1'b0, alu_b} + {32'b0, alu_cin};
  assign alu_v      = (ALU_SrcA[31] == alu_b[31]) && (alu_sum[31] != ALU_SrcA[31]);
  assign ALU_Result = alu_sum[31:0];
  assign ALU_Flags  = {alu_sum[31], (alu_sum[31:0] == 32'b0), alu_sum[32], alu_v};

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // {Result2, Result1} from plain arithmetic
  function automatic logic [63:0] golden(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (!op) begin
      p = {32'b0, a} * {32'b0, b};
      return p;
    end
    if (b == 32'b0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Model: an operation occupies 32 cycles after its Start edge, then Done for one cycle.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        m_op = 1'b0;
  logic [63:0] m_pend = '0;
  logic [31:0] m_r1 = '0;
  logic [31:0] m_r2 = '0;

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_op   <= 1'b0;
      m_pend <= '0;
      m_r1   <= '0;
      m_r2   <= '0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_r1 <= m_pend[31:0];
        m_r2 <= m_pend[63:32];
      end
    end else begin
      m_done <= 1'b0;
      if (Start) begin
        m_left <= 32;
        m_op   <= MCycleOp;
        m_pend <= golden(MCycleOp, Operand1, Operand2);
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy", 80'((m_left != 0) | Start), 80'(Busy));
      chk("own", 80'(ALU_Own), 80'(m_left != 0));
      chk("done", 80'(Done), 80'(m_done));
      chk("result1", 80'(Result1), 80'(m_r1));
      chk("result2", 80'(Result2), 80'(m_r2));
      if (m_left != 0) begin
        chk("alu_ctrl", 80'(ALU_Control), 80'(m_op ? 4'b0001 : 4'b0000));
        chk("alu_misc", 80'({ALU_isArith, ALU_isADC, ALU_CFlag}), 80'(3'b101));
      end else begin
        chk("alu_idle", 80'({ALU_SrcA, ALU_SrcB, ALU_Control, ALU_isArith, ALU_isADC, ALU_CFlag}), 80'(0));
      end
    end
  end

  task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b);
    @(posedge CLK);
    #1;
    Start    = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
  endtask

  task automatic wait_done(output int cyc, input bit drop);
    bit seen;
    seen = 0;
    cyc  = 0;
    while (cyc < 40 && !seen) begin
      @(posedge CLK);
      cyc++;
      #1;
      if (drop) Start = 1'b0;
      @(negedge CLK);
      if (Done) seen = 1;
    end
    if (!seen) chk("done_timeout", 80'(0), 80'(1));
  endtask

  task automatic run_op(input string name, input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e1, input logic [31:0] e2);
    int cyc;
    start_op(op, a, b);
    wait_done(cyc, 1'b1);
    chk({name, "_latency"}, 80'(cyc), 80'(33));
    chk({name, "_r1"}, 80'(Result1), 80'(e1));
    chk({name, "_r2"}, 80'(Result2), 80'(e2));
  endtask

  initial begin
    int cyc;
    int c;
    bit seen;
    CLK      = 1'b0;
    RESETn   = 1'b1;
    Start    = 1'b0;
    MCycleOp = 1'b0;
    Operand1 = '0;
    Operand2 = '0;
    #2 RESETn = 1'b0;
    #1;
    chk("reset_outs", 80'({Busy, Done, ALU_Own, Result1, Result2}), 80'(0));
    chk("reset_alu", 80'({ALU_SrcA, ALU_SrcB, ALU_Control, ALU_isArith, ALU_isADC, ALU_CFlag}), 80'(0));
    chk_en = 1;
    @(posedge CLK);
    @(posedge CLK);
    #1 RESETn = 1'b1;

    run_op("mul_7x6", 1'b0, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 32'h0000_0000);
    run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002);
    run_op("div_topbit", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 32'h7FFF_FFFE);
    run_op("div_zero", 1'b1, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678);

    // Start during RUN is ignored
    start_op(1'b0, 32'd5, 32'd5);
    @(posedge CLK);
    #1 Start = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    Start    = 1'b1;
    MCycleOp = 1'b1;
    Operand1 = 32'd9;
    Operand2 = 32'd3;
    @(posedge CLK);
    #1 Start = 1'b0;
    wait_done(cyc, 1'b1);
    chk("ignore_r1", 80'(Result1), 80'(32'd25));
    chk("ignore_r2", 80'(Result2), 80'(32'd0));

    // Reset mid-operation aborts at once
    start_op(1'b0, 32'd3, 32'd4);
    @(posedge CLK);
    #1 Start = 1'b0;
    repeat (9) @(posedge CLK);
    #1 RESETn = 1'b0;
    #1;
    chk("abort_ctl", 80'({Busy, Done, ALU_Own}), 80'(0));
    chk("abort_res", 80'({Result1, Result2}), 80'(0));
    @(posedge CLK);
    #1 RESETn = 1'b1;

    // Start held through DONE: next operation follows with no IDLE cycle
    start_op(1'b0, 32'h0001_0000, 32'h0001_0000);
    c    = 0;
    seen = 0;
    while (c < 40 && !seen) begin
      @(posedge CLK);
      c++;
      #1;
      if (c == 5) begin
        MCycleOp = 1'b1;
        Operand1 = 32'd100;
        Operand2 = 32'd7;
      end
      @(negedge CLK);
      if (Done) seen = 1;
    end
    if (!seen) chk("b2b_timeout", 80'(0), 80'(1));
    chk("b2b_latency", 80'(c), 80'(33));
    chk("b2b_busy_in_done", 80'(Busy), 80'(1));
    chk("b2b_first_res", 80'({Result2, Result1}), 80'(64'h0000_0001_0000_0000));
    @(posedge CLK);
    #1;
    chk("b2b_own_next", 80'({ALU_Own, Done}), 80'(2'b10));
    Start = 1'b0;
    wait_done(cyc, 1'b1);
    chk("b2b_second_latency", 80'(cyc), 80'(32));
    chk("b2b_second_res", 80'({Result2, Result1}), 80'(64'h0000_0002_0000_000E));

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mcycle_alu_sequencer.md
Name: mcycle_alu_sequencer

Overview:
Multi-cycle unsigned 32x32 multiply (64-bit product) and 32/32 divide (quotient and remainder) unit. It has no adder of its own; each iteration borrows the shared ALU.
While running, it owns the ALU input mux (ALU_Own), drives ALU operands and control, and consumes ALUResult/ALUFlags combinationally in the same cycle.
It sits beside the ALU in the execute stage. Busy stalls the pipeline.

Parameters:
WIDTH, 32, operand width (ALU is 32-bit; only 32 is supported)
CNT_W, 5, iteration counter width, equal to clog2(WIDTH)

Ports:
CLK  in  1  clock, rising edge
RESETn  in  1  asynchronous active-low reset
Start  in  1  request a new operation; sampled in IDLE or DONE
MCycleOp  in  1  0=MUL, 1=DIV (unsigned)
Operand1  in  32  multiplicand / dividend
Operand2  in  32  multiplier / divisor
Busy  out  1  operation in progress; pipeline stall
Done  out  1  one-cycle pulse when results become valid
Result1  out  32  MUL product[31:0] / DIV quotient
Result2  out  32  MUL product[63:32] / DIV remainder
ALU_Own  out  1  datapath mux select: the sequencer drives the ALU inputs
ALU_SrcA  out  32  ALU Src_A
ALU_SrcB  out  32  ALU Src_B
ALU_Control  out  4  0000=ADD, 0001=SUB
ALU_isArith  out  1  1 in RUN, so the carry output comes from the adder
ALU_isADC  out  1  always 0
ALU_CFlag  out  1  1 in RUN (plain SUB; no extra borrow)
ALU_Result  in  32  ALUResult
ALU_Flags  in  4  {N,Z,C,V}; C is bit 1

Behaviour:
- Reset (asynchronous, RESETn=0):
  - State goes to IDLE, counter=0, internal registers=0.
  - Result1=Result2=0, Busy=Done=ALU_Own=0.
  - All ALU_* outputs = 0.
  - Reset mid-operation aborts the operation with no partial results retained.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if Start=1, latch Operand1/Operand2/MCycleOp, clear the counter, go to RUN. Otherwise stay.
  - RUN: exactly WIDTH cycles, one iteration per cycle. When counter=WIDTH-1, go to DONE. Otherwise increment the counter.
  - DONE: Done=1 for one cycle and Result1/Result2 are updated. If Start=1, load new operands and go to RUN (back-to-back). Otherwise go to IDLE.
- Busy is combinational: (IDLE & Start) | RUN | (DONE & Start). The stall is therefore visible in the Start cycle.
- Start while in RUN is ignored.
- Latency: Start sampled at edge 0 → RUN occupies cycles 1..32 → Done=1 in cycle 33.
- Result1/Result2 are updated only on the RUN→DONE edge and held until the next RUN→DONE edge or reset.
- ALU_Own=1 only in RUN. Outside RUN, all ALU_* outputs = 0.
- MUL (shift-add). Registers: hi (32, init 0), lo (32, init Operand2), mcand (Operand1).
  - ALU drive: ADD, SrcA=hi, SrcB=mcand.
  - If lo[0]=1: {hi,lo} ← {ALU_Flags[1], ALU_Result, lo} >> 1.
  - Else: {hi,lo} ← {1'b0, hi, lo} >> 1.
  - At completion: Result1=lo, Result2=hi.
- DIV (restoring). Registers: rem (32, init 0), q (32, init Operand1), dvsr (Operand2).
  - Each cycle: sh={rem[30:0],q[31]} and top=rem[31].
  - ALU drive: SUB, SrcA=sh, SrcB=dvsr, CFlag=1.
  - If top | ALU_Flags[1]: rem ← ALU_Result and the new quotient bit=1. Otherwise rem ← sh and the new quotient bit=0.
  - q ← {q[30:0], bit}.
  - At completion: Result1=q, Result2=rem.
- Divide by zero has no special case. It falls out of the algorithm as quotient=0xFFFFFFFF and remainder=dividend, with the same 33-cycle latency.
- ALU_Flags N/Z/V are ignored. Only C is used.

Decomposition:
- Shared package mcycle_pkg holds:
  - state encoding (IDLE/RUN/DONE);
  - ALU opcode constants ALU_ADD=4'b0000, ALU_SUB=4'b0001;
  - OP_MUL=1'b0, OP_DIV=1'b1;
  - FLAG_C=1 (index into ALU_Flags).
- A single module is sufficient; no sub-module. The bench instantiates the real ALU in the loop.

Test Plan:
- MUL 0x00000007 × 0x00000006 → Done in cycle 33; Result1=0x0000002A, Result2=0x00000000; Busy high cycles 0..32.
- MUL 0xFFFFFFFF × 0xFFFFFFFF → Result1=0x00000001, Result2=0xFFFFFFFE (exercises the carry-into-hi path).
- DIV 100/7 → Result1=0x0000000E, Result2=0x00000002.
- DIV 0xFFFFFFFF/0x80000001 → Result1=0x00000001, Result2=0x7FFFFFFE (exercises the top-bit path).
- DIV 0x12345678/0 → Result1=0xFFFFFFFF, Result2=0x12345678.
- Start MUL 5×5; pulse Start with different operands at RUN cycle 10 → ignored, result 25.
  - Assert RESETn=0 at RUN cycle 10 of a second operation → Busy=Done=ALU_Own=0 and results=0 immediately.
  - Then a Start held high through DONE → the next operation begins with no IDLE cycle.
